// File: rtl/lock_result_checker.sv
// Response checker for the locked carry-lookahead adder key sweep: compares each
// locked result against the golden sum and reports a per-key-session verdict.
module lock_result_checker #(
  parameter int WIDTH       = 32,
  parameter int KEY_W       = 64,
  parameter int VEC_PER_KEY = 15,
  parameter int CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               key_valid_i,
  input  logic               vec_valid_i,
  input  logic [WIDTH-1:0]   add1_i,
  input  logic [WIDTH-1:0]   add2_i,
  input  logic [WIDTH:0]     result_i,
  output logic               vec_ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               key_ok_o,
  output logic [KEY_W-1:0]   last_key_o,
  output logic [CNT_W-1:0]   mismatch_cnt_o,
  output logic [7:0]         first_fail_idx_o,
  output logic [WIDTH:0]     diff_acc_o
);

  localparam int         RES_W    = WIDTH + 1;
  localparam logic [7:0] LAST_IDX = 8'(VEC_PER_KEY - 1);
  localparam logic [7:0] NO_FAIL  = 8'hFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             drain_cnt;
  logic [7:0]       vec_idx;
  logic             acc_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [RES_W-1:0] res_p1;
  logic [7:0]       idx_p1;

  logic             vld_p2;
  logic [RES_W-1:0] diff_p2;
  logic [7:0]       idx_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RES_W-1:0] golden_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // A key restart in the same cycle drops the vector
  assign acc_p0 = vec_valid_i && (state == RUN) && !key_valid_i;

  always_comb begin
    state_nxt   = state;
    vec_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    key_ok_o    = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        vec_ready_o = 1'b1;
        busy_o      = 1'b1;
        if (acc_p0 && (vec_idx == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (drain_cnt) state_nxt = REPORT;
      end
      REPORT: begin
        done_o    = 1'b1;
        key_ok_o  = (mismatch_cnt_o == '0);
        state_nxt = IDLE;
      end
    endcase
    // A new key always (re)starts a session; REPORT still shows its done pulse
    if (key_valid_i) state_nxt = RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      drain_cnt        <= 1'b0;
      vec_idx          <= '0;
      vld_p1           <= 1'b0;
      vld_p2           <= 1'b0;
      last_key_o       <= '0;
      mismatch_cnt_o   <= '0;
      diff_acc_o       <= '0;
      first_fail_idx_o <= NO_FAIL;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      vld_p1    <= acc_p0;
      vld_p2    <= vld_p1 && !key_valid_i;
      if (key_valid_i) begin
        last_key_o       <= key_i;
        vec_idx          <= '0;
        mismatch_cnt_o   <= '0;
        diff_acc_o       <= '0;
        first_fail_idx_o <= NO_FAIL;
      end else begin
        if (acc_p0) vec_idx <= vec_idx + 8'd1;
        // stage 2 commit
        if (vld_p2 && (diff_p2 != '0)) begin
          mismatch_cnt_o <= sat_inc(mismatch_cnt_o);
          diff_acc_o     <= diff_acc_o | diff_p2;
          if (first_fail_idx_o == NO_FAIL) first_fail_idx_o <= idx_p2;
        end
      end
    end
  end

  // stage 0 -> stage 1: capture accepted vector
  always_ff @(posedge clk_i) begin
    if (acc_p0) begin
      a_p1   <= add1_i;
      b_p1   <= add2_i;
      res_p1 <= result_i;
      idx_p1 <= vec_idx;
    end
  end

  // stage 1 -> stage 2: golden compare
  always_ff @(posedge clk_i) begin
    diff_p2 <= golden_sum(a_p1, b_p1) ^ res_p1;
    idx_p2  <= idx_p1;
  end

endmodule

// File: tb/tb_lock_result_checker.sv
// Bench for lock_result_checker: table-driven sessions, hand-written abort/reset
// sequences, and randomized sessions checked against an arithmetic model.
module tb_lock_result_checker;

  localparam int WIDTH = 32;
  localparam int KEY_W = 64;
  localparam int VPK   = 15;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } vec_t;

  typedef struct {
    int             bad0;
    logic [WIDTH:0] m0;
    int             bad1;
    logic [WIDTH:0] m1;
    int             exp_cnt;
    int             exp_first;
    logic [WIDTH:0] exp_diff;
    bit             gaps;
  } scen_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, key_valid, vec_valid;
  logic [KEY_W-1:0] key;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   res;

  logic             rdy, busy, done, ok;
  logic [KEY_W-1:0] lkey;
  logic [7:0]       cnt;
  logic [7:0]       first;
  logic [WIDTH:0]   dacc;

  logic             rdy2, busy2, done2, ok2;
  logic [KEY_W-1:0] lkey2;
  logic [1:0]       cnt2;
  logic [7:0]       first2;
  logic [WIDTH:0]   dacc2;

  lock_result_checker dut (
    .clk_i(clk), .rst_i(rst), .key_i(key), .key_valid_i(key_valid),
    .vec_valid_i(vec_valid), .add1_i(a), .add2_i(b), .result_i(res),
    .vec_ready_o(rdy), .busy_o(busy), .done_o(done), .key_ok_o(ok),
    .last_key_o(lkey), .mismatch_cnt_o(cnt), .first_fail_idx_o(first),
    .diff_acc_o(dacc)
  );

  lock_result_checker #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .key_i(key), .key_valid_i(key_valid),
    .vec_valid_i(vec_valid), .add1_i(a), .add2_i(b), .result_i(res),
    .vec_ready_o(rdy2), .busy_o(busy2), .done_o(done2), .key_ok_o(ok2),
    .last_key_o(lkey2), .mismatch_cnt_o(cnt2), .first_fail_idx_o(first2),
    .diff_acc_o(dacc2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  vec_t             vt [VPK];
  scen_t            st [4];
  logic [WIDTH-1:0] sa [VPK];
  logic [WIDTH-1:0] sb [VPK];
  logic [WIDTH:0]   sr [VPK];

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Reference: plain arithmetic over the whole session
  function automatic void model(input int cap, output int e_cnt, output int e_first,
                                output logic [WIDTH:0] e_diff);
    logic [WIDTH:0] g;
    e_cnt = 0; e_first = 255; e_diff = '0;
    for (int i = 0; i < VPK; i++) begin
      g = {1'b0, sa[i]} + {1'b0, sb[i]};
      if (g != sr[i]) begin
        e_cnt++;
        if (e_first == 255) e_first = i;
        e_diff |= g ^ sr[i];
      end
    end
    if (e_cnt > cap) e_cnt = cap;
  endfunction

  task automatic start_key(input logic [KEY_W-1:0] k);
    key = k; key_valid = 1'b1; vec_valid = 1'b0;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_vectors(input string tag, input int n, input bit gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int j = 0; j < g; j++) begin
        vec_valid = 1'b0; a = $urandom; b = $urandom;
        chk(tag, "ready_gap", 64'(rdy), 64'(1));
        tick();
      end
      a = sa[i]; b = sb[i]; res = sr[i]; vec_valid = 1'b1;
      chk(tag, "ready_run", 64'(rdy), 64'(1));
      tick();
    end
  endtask

  task automatic run_session(input string tag, input logic [KEY_W-1:0] k, input bit do_key,
                             input bit gaps, input int e_cnt, input int e_first,
                             input logic [WIDTH:0] e_diff, input int e_cnt2);
    if (do_key) start_key(k);
    send_vectors(tag, VPK, gaps);
    // garbage vectors outside RUN must be ignored
    vec_valid = 1'b1; a = $urandom; b = $urandom; res = '1;
    chk(tag, "ready_drain1", 64'(rdy), 64'(0));
    chk(tag, "busy_drain1", 64'(busy), 64'(1));
    chk(tag, "done_drain1", 64'(done), 64'(0));
    tick();
    chk(tag, "done_drain2", 64'(done), 64'(0));
    chk(tag, "ready_drain2", 64'(rdy), 64'(0));
    tick();
    chk(tag, "done", 64'(done), 64'(1));
    chk(tag, "key_ok", 64'(ok), 64'(e_cnt == 0));
    chk(tag, "mismatch_cnt", 64'(cnt), 64'(e_cnt));
    chk(tag, "first_fail", 64'(first), 64'(e_first));
    chk(tag, "diff_acc", 64'(dacc), 64'(e_diff));
    chk(tag, "last_key", lkey, k);
    chk(tag, "ready_report", 64'(rdy), 64'(0));
    chk(tag, "cnt_w2", 64'(cnt2), 64'(e_cnt2));
    tick();
    vec_valid = 1'b0;
    chk(tag, "done_idle", 64'(done), 64'(0));
    chk(tag, "ready_idle", 64'(rdy), 64'(0));
    chk(tag, "cnt_hold", 64'(cnt), 64'(e_cnt));
    chk(tag, "diff_hold", 64'(dacc), 64'(e_diff));
  endtask

  task automatic load_table();
    for (int i = 0; i < VPK; i++) begin
      sa[i] = vt[i].a; sb[i] = vt[i].b; sr[i] = vt[i].sum;
    end
  endtask

  initial begin
    logic [KEY_W-1:0] k0, k1;
    logic [WIDTH:0]   m, e_diff;
    int               e_cnt, e_first, e_cnt2, e_f2, d0;
    logic [WIDTH:0]   e_d2;

    vt[0]  = '{32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABEEC};
    vt[1]  = '{32'h00000000, 32'h00000000, 33'h0_00000000};
    vt[2]  = '{32'hFFFFFFFF, 32'h00000001, 33'h1_00000000};
    vt[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1_FFFFFFFE};
    vt[4]  = '{32'h12345678, 32'h11111111, 33'h0_23456789};
    vt[5]  = '{32'h7FFFFFFF, 32'h00000001, 33'h0_80000000};
    vt[6]  = '{32'h00000001, 32'h00000001, 33'h0_00000002};
    vt[7]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 33'h0_FFFFFFFF};
    vt[8]  = '{32'h80000000, 32'h80000000, 33'h1_00000000};
    vt[9]  = '{32'h55555555, 32'hAAAAAAAA, 33'h0_FFFFFFFF};
    vt[10] = '{32'h80519860, 32'h8086BA3E, 33'h1_00D8529E};
    vt[11] = '{32'h00010000, 32'h0000FFFF, 33'h0_0001FFFF};
    vt[12] = '{32'hDEADBEEF, 32'h00000000, 33'h0_DEADBEEF};
    vt[13] = '{32'h01234567, 32'hFEDCBA98, 33'h0_FFFFFFFF};
    vt[14] = '{32'h00000003, 32'hFFFFFFFD, 33'h1_00000000};

    st[0] = '{-1, 33'h0, -1, 33'h0, 0, 255, 33'h0, 1'b0};
    st[1] = '{9, 33'h0_00000001, 10, 33'h1_00000000, 2, 9, 33'h1_00000001, 1'b0};
    st[2] = '{14, 33'h0_00000020, 3, 33'h1_00000000, 2, 3, 33'h1_00000020, 1'b1};
    st[3] = '{0, 33'h1_FFFFFFFF, -1, 33'h0, 1, 0, 33'h1_FFFFFFFF, 1'b1};

    k0 = 64'hED06C024C5BF39E2;
    k1 = 64'hED06C024C5BF39E0;
    rst = 1'b1; key_valid = 1'b0; vec_valid = 1'b0; key = '0; a = '0; b = '0; res = '0;
    tick();
    chk("reset", "ready", 64'(rdy), 64'(0));
    chk("reset", "busy", 64'(busy), 64'(0));
    chk("reset", "done", 64'(done), 64'(0));
    chk("reset", "key_ok", 64'(ok), 64'(0));
    chk("reset", "last_key", lkey, 64'(0));
    chk("reset", "cnt", 64'(cnt), 64'(0));
    chk("reset", "first", 64'(first), 64'hFF);
    chk("reset", "diff", 64'(dacc), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // Table-driven sessions
    for (int s = 0; s < 4; s++) begin
      load_table();
      for (int i = 0; i < VPK; i++) begin
        if (i == st[s].bad0) sr[i] = sr[i] ^ st[s].m0;
        if (i == st[s].bad1) sr[i] = sr[i] ^ st[s].m1;
      end
      run_session($sformatf("table%0d", s), k0, 1'b1, st[s].gaps, st[s].exp_cnt,
                  st[s].exp_first, st[s].exp_diff, (st[s].exp_cnt > 3) ? 3 : st[s].exp_cnt);
    end

    // Abort after 6 vectors (errors already committed and in flight)
    d0 = done_cnt;
    load_table();
    sr[1] = sr[1] ^ 33'h4;
    sr[5] = sr[5] ^ 33'h8;
    start_key(k0);
    send_vectors("abort", 6, 1'b0);
    key = k1; key_valid = 1'b1; a = sa[6]; b = sb[6]; res = '0; vec_valid = 1'b1;
    tick();
    key_valid = 1'b0; vec_valid = 1'b0;
    chk("abort", "last_key", lkey, k1);
    chk("abort", "cnt_clear", 64'(cnt), 64'(0));
    chk("abort", "first_clear", 64'(first), 64'hFF);
    chk("abort", "diff_clear", 64'(dacc), 64'(0));
    chk("abort", "ready", 64'(rdy), 64'(1));
    load_table();
    run_session("abort_run", k1, 1'b0, 1'b0, 0, 255, 33'h0, 0);
    chk("abort", "done_pulses", 64'(done_cnt - d0), 64'(1));

    // Reset during DRAIN
    load_table();
    sr[2] = sr[2] ^ 33'h1;
    start_key(k0);
    send_vectors("rst_drain", VPK, 1'b0);
    d0 = done_cnt;
    vec_valid = 1'b0;
    chk("rst_drain", "busy_in_drain", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drain", "ready", 64'(rdy), 64'(0));
    chk("rst_drain", "busy", 64'(busy), 64'(0));
    chk("rst_drain", "done", 64'(done), 64'(0));
    chk("rst_drain", "last_key", lkey, 64'(0));
    chk("rst_drain", "cnt", 64'(cnt), 64'(0));
    chk("rst_drain", "first", 64'(first), 64'hFF);
    chk("rst_drain", "diff", 64'(dacc), 64'(0));
    for (int i = 0; i < 5; i++) begin
      a = sa[i]; b = sb[i]; res = '1; vec_valid = 1'b1;
      tick();
      chk("rst_drain", "ready_ignored", 64'(rdy), 64'(0));
    end
    vec_valid = 1'b0;
    chk("rst_drain", "no_done", 64'(done_cnt - d0), 64'(0));
    chk("rst_drain", "cnt_still0", 64'(cnt), 64'(0));
    run_session("after_rst", k1, 1'b1, 1'b0, 1, 2, 33'h1, 1);

    // All vectors wrong: saturation in the narrow-counter instance
    load_table();
    for (int i = 0; i < VPK; i++) sr[i] = sr[i] ^ 33'h1;
    run_session("saturate", k0, 1'b1, 1'b1, 15, 0, 33'h1, 3);

    // Randomized sessions against the arithmetic model
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < VPK; i++) begin
        sa[i] = $urandom; sb[i] = $urandom;
        sr[i] = {1'b0, sa[i]} + {1'b0, sb[i]};
        if ($urandom_range(0, 3) == 0) begin
          m = {1'($urandom_range(0, 1)), 32'($urandom)};
          if (m == '0) m = 33'h1;
          sr[i] = sr[i] ^ m;
        end
      end
      model(255, e_cnt, e_first, e_diff);
      model(3, e_cnt2, e_f2, e_d2);
      run_session($sformatf("rand%0d", s), {32'($urandom), 32'($urandom)}, 1'b1, 1'b1,
                  e_cnt, e_first, e_diff, e_cnt2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
